// File: rtl/cmd_issuer_pkg.sv
// Shared types and constants for the command-issue stage in front of the
// 8-bit load/increment counter.
package cmd_issuer_pkg;

    // Width of the repeat field stored in each queued command.
    localparam int CMD_REP_W = 8;

    // Counter command encodings.
    localparam logic CMD_LOAD = 1'b0;
    localparam logic CMD_INCR = 1'b1;

    // One queued command as held in the FIFO.
    typedef struct packed {
        logic                 cmd;
        logic [7:0]           data;
        logic [7:0]           addr;
        logic [CMD_REP_W-1:0] rep;
    } cmd_entry_t;

    // Issue FSM: LOAD/INCR name the command whose cycle was just driven.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        INCR = 2'd2
    } issue_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO for queued commands. Pointers carry one extra wrap bit so
// full/empty are decoded from the MSB compare; pointer wrap is natural.
module cmd_fifo
    import cmd_issuer_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = cmd_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  entry_t wdata,
    output entry_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    entry_t      mem_r [DEPTH];

    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign rdata = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer and storage update; reset clears both so no stale entry survives.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                mem_r[wr_ptr_r[AW-1:0]] <= wdata;
                wr_ptr_r                <= wr_ptr_r + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/cmd_issuer.sv
// Command-issue stage for the load/increment counter. Queues commands, then
// drives one counter step per clock; when idle it reloads the counter with its
// own value (shadow) since the counter has no enable.
module cmd_issuer
    import cmd_issuer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int REP_W = CMD_REP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_cmd,
    input  logic [7:0]       in_data,
    input  logic [7:0]       in_addr,
    input  logic [REP_W-1:0] in_rep,
    output logic             cmd,
    output logic [7:0]       data,
    output logic [7:0]       addr,
    output logic [7:0]       exp_count,
    output logic             busy,
    output logic [15:0]      issued
);

    localparam logic [CMD_REP_W-1:0] REP_ZERO = {CMD_REP_W{1'b0}};
    localparam logic [CMD_REP_W-1:0] REP_ONE  = {{(CMD_REP_W-1){1'b0}}, 1'b1};

    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          push_s;
    logic          pop_s;
    logic          slot_free_s;
    logic          issued_inc_s;
    cmd_entry_t    in_entry_s;
    cmd_entry_t    head_s;

    issue_state_t  state_r,   state_nxt_s;
    logic [CMD_REP_W-1:0] rep_cnt_r, rep_cnt_nxt_s;
    logic          cmd_r,     cmd_nxt_s;
    logic [7:0]    data_r,    data_nxt_s;
    logic [7:0]    addr_r,    addr_nxt_s;
    logic [7:0]    shadow_r,  shadow_nxt_s;
    logic [15:0]   issued_r;

    // No push while full, even if a pop happens in the same cycle.
    assign in_ready = !fifo_full_s && rst;
    assign push_s   = in_valid && in_ready;

    assign in_entry_s.cmd  = in_cmd;
    assign in_entry_s.data = in_data;
    assign in_entry_s.addr = in_addr;
    assign in_entry_s.rep  = in_rep;

    assign cmd       = cmd_r;
    assign data      = data_r;
    assign addr      = addr_r;
    assign exp_count = shadow_r;
    assign issued    = issued_r;
    assign busy      = (state_r != IDLE) || !fifo_empty_s;

    cmd_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (cmd_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (in_entry_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Next-issue decision: continue a burst, start the head command, or hold.
    always_comb begin
        state_nxt_s   = state_r;
        rep_cnt_nxt_s = rep_cnt_r;
        cmd_nxt_s     = CMD_LOAD;
        data_nxt_s    = shadow_r;
        addr_nxt_s    = addr_r;
        shadow_nxt_s  = shadow_r;
        issued_inc_s  = 1'b0;
        pop_s         = 1'b0;

        case (state_r)
            IDLE:    slot_free_s = 1'b1;
            LOAD:    slot_free_s = 1'b1;
            INCR:    slot_free_s = (rep_cnt_r == REP_ZERO);
            default: slot_free_s = 1'b1;
        endcase

        if (slot_free_s) begin
            if (!fifo_empty_s) begin
                pop_s      = 1'b1;
                addr_nxt_s = head_s.addr;
                if (head_s.cmd == CMD_LOAD) begin
                    state_nxt_s   = LOAD;
                    rep_cnt_nxt_s = REP_ZERO;
                    data_nxt_s    = head_s.data;
                    shadow_nxt_s  = head_s.data;
                    issued_inc_s  = 1'b1;
                end else begin
                    state_nxt_s   = INCR;
                    rep_cnt_nxt_s = head_s.rep;
                    cmd_nxt_s     = CMD_INCR;
                    data_nxt_s    = 8'h00;
                    shadow_nxt_s  = shadow_r + 8'h01;
                    issued_inc_s  = (head_s.rep == REP_ZERO);
                end
            end else begin
                // Hold: counter reloads its own value, addr stays put.
                state_nxt_s   = IDLE;
                rep_cnt_nxt_s = REP_ZERO;
            end
        end else begin
            rep_cnt_nxt_s = rep_cnt_r - REP_ONE;
            cmd_nxt_s     = CMD_INCR;
            data_nxt_s    = 8'h00;
            shadow_nxt_s  = shadow_r + 8'h01;
            issued_inc_s  = (rep_cnt_r == REP_ONE);
        end
    end

    // State, registered counter outputs, shadow and completion counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= IDLE;
            rep_cnt_r <= REP_ZERO;
            cmd_r     <= CMD_LOAD;
            data_r    <= 8'h00;
            addr_r    <= 8'h00;
            shadow_r  <= 8'h00;
            issued_r  <= 16'h0000;
        end else begin
            state_r   <= state_nxt_s;
            rep_cnt_r <= rep_cnt_nxt_s;
            cmd_r     <= cmd_nxt_s;
            data_r    <= data_nxt_s;
            addr_r    <= addr_nxt_s;
            shadow_r  <= shadow_nxt_s;
            issued_r  <= issued_r + (issued_inc_s ? 16'h0001 : 16'h0000);
        end
    end

endmodule

// File: tb/tb_cmd_issuer.sv
// Directed bench for cmd_issuer with a behavioural model of the downstream
// load/increment counter so the shadow can be compared to the counter output.
module tb_cmd_issuer;

    localparam int DEPTH = 4;
    localparam int REP_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_cmd;
    logic [7:0]       in_data;
    logic [7:0]       in_addr;
    logic [REP_W-1:0] in_rep;
    logic             cmd;
    logic [7:0]       data;
    logic [7:0]       addr;
    logic [7:0]       exp_count;
    logic             busy;
    logic [15:0]      issued;

    int n_vec = 0;
    int n_err = 0;

    // Test 3 / test 4 expectation tables
    logic [7:0] t3_exp [6];
    logic       t3_cmd [6];
    logic       s_cmd  [6];
    logic [7:0] s_data [6];
    logic [7:0] s_addr [6];
    logic [7:0] s_rep  [6];
    logic       e_cmd  [18];
    logic [7:0] e_data [18];
    logic [7:0] e_addr [18];
    logic [7:0] e_exp  [18];
    logic [7:0] prev;
    logic [7:0] sh;
    logic [7:0] la;
    int         k;
    int         w;

    always #5 clk = ~clk;

    cmd_issuer #(.DEPTH(DEPTH), .REP_W(REP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cmd    (in_cmd),
        .in_data   (in_data),
        .in_addr   (in_addr),
        .in_rep    (in_rep),
        .cmd       (cmd),
        .data      (data),
        .addr      (addr),
        .exp_count (exp_count),
        .busy      (busy),
        .issued    (issued)
    );

    // Downstream counter model: cmd=1 increments, cmd=0 loads data.
    logic [7:0] ctr_dout;
    always @(posedge clk) begin
        if (!rst) ctr_dout <= 8'h00;
        else if (cmd) ctr_dout <= ctr_dout + 8'h01;
        else ctr_dout <= data;
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_io(input string tag, input logic c, input logic [7:0] d,
                            input logic [7:0] a, input logic [7:0] e);
        check_vec({tag, ".cmd"},  {31'd0, cmd}, {31'd0, c});
        check_vec({tag, ".data"}, {24'd0, data}, {24'd0, d});
        check_vec({tag, ".addr"}, {24'd0, addr}, {24'd0, a});
        check_vec({tag, ".exp"},  {24'd0, exp_count}, {24'd0, e});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_cmd = 1'b0;
        in_data = 8'h00; in_addr = 8'h00; in_rep = 8'h00;

        // ---------- reset state ----------
        tick; tick;
        check_io("rst", 1'b0, 8'h00, 8'h00, 8'h00);
        check_vec("rst.issued", {16'd0, issued}, 32'd0);
        check_vec("rst.busy", {31'd0, busy}, 32'd0);
        check_vec("rst.ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check_vec("rel.ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick;
            check_io("idle", 1'b0, 8'h00, 8'h00, 8'h00);
            check_vec("idle.busy", {31'd0, busy}, 32'd0);
            check_vec("idle.ready", {31'd0, in_ready}, 32'd1);
        end

        // ---------- load 3C then incr rep=2 ----------
        in_valid = 1'b1; in_cmd = 1'b0; in_data = 8'h3C; in_addr = 8'h11; in_rep = 8'h00;
        check_vec("t2.ready", {31'd0, in_ready}, 32'd1);
        tick;
        check_io("t2.pre", 1'b0, 8'h00, 8'h00, 8'h00);
        in_cmd = 1'b1; in_data = 8'hAA; in_addr = 8'h22; in_rep = 8'h02;
        tick;
        in_valid = 1'b0;
        check_io("t2.ld", 1'b0, 8'h3C, 8'h11, 8'h3C);
        check_vec("t2.iss1", {16'd0, issued}, 32'd1);
        tick; check_io("t2.i0", 1'b1, 8'h00, 8'h22, 8'h3D);
        tick; check_io("t2.i1", 1'b1, 8'h00, 8'h22, 8'h3E);
        tick; check_io("t2.i2", 1'b1, 8'h00, 8'h22, 8'h3F);
        check_vec("t2.iss2", {16'd0, issued}, 32'd2);
        check_vec("t2.busy", {31'd0, busy}, 32'd1);
        tick; check_io("t2.hold", 1'b0, 8'h3F, 8'h22, 8'h3F);
        check_vec("t2.dout", {24'd0, ctr_dout}, 32'h3F);
        check_vec("t2.idle", {31'd0, busy}, 32'd0);

        // ---------- load FE then incr rep=3 (wrap) ----------
        t3_exp[0] = 8'hFE; t3_exp[1] = 8'hFF; t3_exp[2] = 8'h00;
        t3_exp[3] = 8'h01; t3_exp[4] = 8'h02; t3_exp[5] = 8'h02;
        t3_cmd[0] = 1'b0; t3_cmd[1] = 1'b1; t3_cmd[2] = 1'b1;
        t3_cmd[3] = 1'b1; t3_cmd[4] = 1'b1; t3_cmd[5] = 1'b0;
        in_valid = 1'b1; in_cmd = 1'b0; in_data = 8'hFE; in_addr = 8'h33; in_rep = 8'h00;
        tick;
        in_cmd = 1'b1; in_data = 8'h5A; in_addr = 8'h44; in_rep = 8'h03;
        tick;
        in_valid = 1'b0;
        prev = 8'h3F;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick;
            check_vec("t3.exp", {24'd0, exp_count}, {24'd0, t3_exp[i]});
            check_vec("t3.cmd", {31'd0, cmd}, {31'd0, t3_cmd[i]});
            check_vec("t3.dout", {24'd0, ctr_dout}, {24'd0, prev});
            prev = t3_exp[i];
        end
        check_vec("t3.iss", {16'd0, issued}, 32'd4);

        // ---------- DEPTH+1 commands behind a long burst ----------
        s_cmd[0] = 1'b1; s_data[0] = 8'hE0; s_addr[0] = 8'hB0; s_rep[0] = 8'd9;
        s_cmd[1] = 1'b0; s_data[1] = 8'h10; s_addr[1] = 8'hB1; s_rep[1] = 8'd0;
        s_cmd[2] = 1'b1; s_data[2] = 8'hE2; s_addr[2] = 8'hB2; s_rep[2] = 8'd1;
        s_cmd[3] = 1'b0; s_data[3] = 8'h20; s_addr[3] = 8'hB3; s_rep[3] = 8'd0;
        s_cmd[4] = 1'b0; s_data[4] = 8'h30; s_addr[4] = 8'hB4; s_rep[4] = 8'd0;
        s_cmd[5] = 1'b1; s_data[5] = 8'hE5; s_addr[5] = 8'hB5; s_rep[5] = 8'd0;
        // Expand the command list into the expected per-edge stream.
        sh = 8'h02; la = 8'h44; k = 0;
        e_cmd[k] = 1'b0; e_data[k] = sh; e_addr[k] = la; e_exp[k] = sh; k++;
        for (int i = 0; i < 6; i++) begin
            la = s_addr[i];
            if (!s_cmd[i]) begin
                sh = s_data[i];
                e_cmd[k] = 1'b0; e_data[k] = sh; e_addr[k] = la; e_exp[k] = sh; k++;
            end else begin
                for (int j = 0; j <= int'(s_rep[i]); j++) begin
                    sh = sh + 8'h01;
                    e_cmd[k] = 1'b1; e_data[k] = 8'h00; e_addr[k] = la; e_exp[k] = sh; k++;
                end
            end
        end
        e_cmd[k] = 1'b0; e_data[k] = sh; e_addr[k] = la; e_exp[k] = sh;

        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    in_cmd = s_cmd[i]; in_data = s_data[i]; in_addr = s_addr[i]; in_rep = s_rep[i];
                    in_valid = 1'b1;
                    if (i == 5) check_vec("t4.full", {31'd0, in_ready}, 32'd0);
                    w = 0;
                    while (!in_ready && w < 40) begin
                        tick;
                        w++;
                    end
                    check_vec("t4.wait", w, (i == 5) ? 32'd7 : 32'd0);
                    tick;
                end
                in_valid = 1'b0;
            end
            begin
                for (int m = 0; m < 18; m++) begin
                    tick;
                    check_io("t4.seq", e_cmd[m], e_data[m], e_addr[m], e_exp[m]);
                end
            end
        join
        check_vec("t4.iss", {16'd0, issued}, 32'd10);
        check_vec("t4.busy", {31'd0, busy}, 32'd0);

        // ---------- reset in the middle of a rep=10 burst ----------
        in_valid = 1'b1; in_cmd = 1'b1; in_data = 8'h00; in_addr = 8'hC0; in_rep = 8'd10;
        tick;
        in_cmd = 1'b0; in_data = 8'h77; in_addr = 8'hC1; in_rep = 8'd0;
        tick;
        in_data = 8'h88; in_addr = 8'hC2;
        tick;
        in_valid = 1'b0;
        check_vec("t5.busy", {31'd0, busy}, 32'd1);
        tick;
        check_io("t5.mid", 1'b1, 8'h00, 8'hC0, 8'h34);
        rst = 1'b0;
        tick;
        check_io("t5.rst", 1'b0, 8'h00, 8'h00, 8'h00);
        check_vec("t5.iss", {16'd0, issued}, 32'd0);
        check_vec("t5.empty", {31'd0, busy}, 32'd0);
        check_vec("t5.ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            check_io("t5.after", 1'b0, 8'h00, 8'h00, 8'h00);
            check_vec("t5.abusy", {31'd0, busy}, 32'd0);
        end

        // ---------- load with addr 0x55 then idle ----------
        in_valid = 1'b1; in_cmd = 1'b0; in_data = 8'h9A; in_addr = 8'h55; in_rep = 8'h00;
        tick;
        in_valid = 1'b0;
        tick;
        check_io("t6.ld", 1'b0, 8'h9A, 8'h55, 8'h9A);
        check_vec("t6.iss", {16'd0, issued}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick;
            check_io("t6.hold", 1'b0, 8'h9A, 8'h55, 8'h9A);
        end
        check_vec("t6.dout", {24'd0, ctr_dout}, 32'h9A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cmd_issuer.md
# cmd_issuer

Upstream command-issue stage for the 8-bit load/increment counter block. Accepts queued commands (load value or increment burst) over a valid/ready handshake, buffers them, and drives the counter's `cmd`/`data`/`addr` inputs one step per clock. The counter has no enable, so this block also keeps a shadow of the counter value and drives a "hold" load when idle. The shadow is exported as the expected counter value for the scoreboard.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `REP_W`, 8: width of the increment repeat field.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous active-low reset.
- `in_valid`  in  1  upstream command valid.
- `in_ready`  out  1  FIFO can accept; `!full && rst`.
- `in_cmd`  in  1  0 = load `in_data`, 1 = increment.
- `in_data`  in  8  load value; ignored when `in_cmd`=1.
- `in_addr`  in  8  address tag carried with the command.
- `in_rep`  in  REP_W  extra increment cycles; ignored for loads.
- `cmd`  out  1  to counter `cmd`, registered.
- `data`  out  8  to counter `data`, registered.
- `addr`  out  8  to counter `addr`, registered.
- `exp_count`  out  8  shadow of counter value after the current edge's update, registered.
- `busy`  out  1  FSM not IDLE or FIFO non-empty.
- `issued`  out  16  count of completed commands; wraps at 2^16.

## Operation
- Push when `in_valid && in_ready` at a rising edge. No push while full, even if a pop occurs in the same cycle.
- FSM states:
  - IDLE: if FIFO is non-empty, pop the head and go to LOAD (cmd 0) or INCR (cmd 1); otherwise issue a hold.
  - LOAD: one cycle.
  - INCR: `rep`+1 cycles.
- Issue encoding:
  - Load: `cmd`=0, `data`=entry data, shadow ← data.
  - Increment step: `cmd`=1, `data`=0, shadow ← shadow+1 mod 256 (255 wraps to 0).
  - Hold (idle): `cmd`=0, `data`=shadow, shadow unchanged, so the counter reloads its own value.
- `addr` takes the entry addr for every cycle of that command. In hold it keeps the last issued addr.
- Back-to-back: in the last cycle of a command, if the FIFO is non-empty, the next command is popped. Its first output appears on the next edge with no hold bubble.
- `issued` increments on the edge that drives the final cycle of each command.
- `exp_count` always equals shadow. After any edge, counter `dout` equals `exp_count` delayed by one edge.

## Timing
- Reset (`rst`=0 at an edge):
  - `cmd`=0, `data`=0, `addr`=0, `exp_count`=0, `issued`=0, `busy`=0.
  - FIFO emptied; FSM to IDLE.
  - `in_ready`=0 while `rst`=0.
- Reset mid-burst aborts the burst and drops all queued entries.
- Latency: a command pushed into an empty FIFO while IDLE at edge T appears on the outputs at edge T+1.
- FIFO pointers are log2(DEPTH)+1 bits; full/empty are decoded from the MSB compare; wrap is natural.
- Maximum throughput: one issued cycle per clock; a load costs 1 cycle, an increment burst costs `rep`+1 cycles.

## Structure
- Package `cmd_issuer_pkg`:
  - `cmd_entry_t` struct {cmd, data[7:0], addr[7:0], rep[REP_W-1:0]}.
  - State enum {IDLE, LOAD, INCR}.
  - Constants `CMD_LOAD`=0, `CMD_INCR`=1.
- Sub-module `cmd_fifo`: synchronous FIFO parameterised by DEPTH and entry type.
  - Ports: push/pop, full/empty, head data.
  - Same clock and reset convention as this block.
- The top level holds the FSM, repeat down-counter, shadow register, and `issued` counter.

## Test plan
- Reset then idle 5 cycles:
  - Expect `cmd`=0, `data`=0, `exp_count`=0, `busy`=0.
  - Expect `in_ready`=1 from the first cycle after `rst` rises.
- Push load 0x3C, then increment with rep=2:
  - Expect outputs to be cmd0/0x3C, then 3× cmd1, then hold cmd0/0x3F.
  - Expect `exp_count` to step 3C, 3D, 3E, 3F.
  - Expect `issued`=2; counter `dout`=0x3F.
- Load 0xFE, increment rep=3:
  - Expect `exp_count` FE, FF, 00, 01, 02 (wrap), matching counter `dout` one edge later.
- Push DEPTH+1 commands with `in_valid` held high:
  - Expect `in_ready`=0 after DEPTH entries are queued.
  - Expect the extra command accepted only after a pop.
  - Expect all commands issued in order with no hold bubbles.
- Assert `rst`=0 for one cycle in the middle of a rep=10 burst with 2 entries queued:
  - Expect all outputs 0 and the FIFO empty next edge.
  - Expect no further cmd1 cycles.
- Load with `in_addr`=0x55 followed by idle:
  - Expect `addr`=0x55 held through the hold cycles.
  - Expect `data`=shadow during the hold cycles.
